// File: rtl/seq_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : seq_bit_serializer
// Purpose  : Parallel-to-serial feeder for the serial sequence detectors.
//            Words arrive over a valid/ready handshake into a one-word
//            holding buffer and are shifted out one bit per clock on `x`.
//            The holding buffer is refilled while the shifter is busy, so
//            consecutive words stream without an idle gap. When nothing is
//            being shifted, `x` carries the fixed IDLE_BIT value.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH     bits per word (2..32)
//   MSB_FIRST 1 = shift MSB first, 0 = LSB first
//   IDLE_BIT  value driven on x while no word is being shifted
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous abort of held and in-flight data
//   in_data    in   [WIDTH] parallel word
//   in_valid   in   in_data valid
//   in_ready   out  holding buffer can accept a word this cycle
//   x          out  serial bit to the detector
//   x_valid    out  x carries a data bit (not idle fill)
//   word_start out  x is the first bit of a new word
//   busy       out  shifter active or holding buffer full
// ============================================================================
module seq_bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_start,
  output logic             busy
);

  localparam int             CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hbuf_q, hbuf_d;
  logic             hfull_q, hfull_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] sreg_shifted;
  logic             out_bit;
  logic             accept;
  logic             load;
  logic             shifting;

  // Bit order only affects which end of the shifter faces the output.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
      assign out_bit      = sreg_q[WIDTH-1];
    end else begin : g_lsb_first
      assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
      assign out_bit      = sreg_q[0];
    end
  endgenerate

  assign shifting = (state_q == ST_SHIFT);
  assign accept   = in_valid && !hfull_q;
  // The shifter takes the held word either when it is idle or on the same
  // edge that retires the final bit of the current word, which is what
  // keeps back-to-back words contiguous.
  assign load     = hfull_q && (!shifting || (cnt_q == C_LAST));

  always_comb begin
    state_d = state_q;
    hbuf_d  = hbuf_q;
    hfull_d = hfull_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;

    if (flush) begin
      // Flush wins over any same-edge accept.
      hfull_d = 1'b0;
      state_d = ST_IDLE;
      cnt_d   = '0;
      sreg_d  = '0;
    end else begin
      if (accept) begin
        hbuf_d  = in_data;
        hfull_d = 1'b1;
      end

      if (load) begin
        // accept and load are mutually exclusive: accept needs hfull_q=0,
        // load needs hfull_q=1.
        sreg_d  = hbuf_q;
        cnt_d   = '0;
        state_d = ST_SHIFT;
        hfull_d = 1'b0;
      end else if (shifting) begin
        if (cnt_q != C_LAST) begin
          sreg_d = sreg_shifted;
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hbuf_q  <= '0;
      hfull_q <= 1'b0;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hbuf_q  <= hbuf_d;
      hfull_q <= hfull_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode from registers only; no input-to-output paths.
  assign in_ready   = !hfull_q;
  assign x_valid    = shifting;
  assign x          = shifting ? out_bit : IDLE_BIT;
  assign word_start = shifting && (cnt_q == '0);
  assign busy       = shifting || hfull_q;

endmodule
`default_nettype wire
